// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the 5-stage pipeline control
package cpu_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic {RUN, MDBUSY} state_t;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: selects the EX operand source, MEM result over WB result over reg file
// Ports: E_R source reg of EX operand; MEM_/WB_ Rdst+RegWrite of later stages; Fwd select
module forward_unit
  import cpu_pkg::*;
(
  input  logic [4:0] E_R,
  input  logic [4:0] MEM_Rdst,
  input  logic       MEM_RegWrite,
  input  logic [4:0] WB_Rdst,
  input  logic       WB_RegWrite,
  output logic [1:0] Fwd
);
  always_comb
    Fwd = (MEM_RegWrite && MEM_Rdst != REG_ZERO && MEM_Rdst == E_R) ? FWD_MEM :
          (WB_RegWrite && WB_Rdst != REG_ZERO && WB_Rdst == E_R) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencing for the 5-stage pipeline with mul/div busy freeze
// Ports: CLK, RST_N (async active-low); ID_* decode operands; EX_*/MEM_*/WB_* later-stage info;
//   StallF/StallD/FlushD/FlushE pipeline control; ForwardAE/BE operand selects; MD_* mul/div status.
// HAZARD_PERF_EN adds PerfStall/PerfFlush cycle counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic       ID_IsMulDiv,
  input  logic [4:0] EX_Rdst,
  input  logic       EX_RegWrite,
  input  logic       EX_MemtoReg,
  input  logic       EX_BranchTaken,
  input  logic [4:0] MEM_Rdst,
  input  logic       MEM_RegWrite,
  input  logic [4:0] WB_Rdst,
  input  logic       WB_RegWrite,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MD_Start,
  output logic       MD_Busy,
  output logic       MD_Done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] PerfStall,
  output logic [31:0] PerfFlush
`endif
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0] e_rs, e_rt;
  logic lu, run, busy;
  // EX_RegWrite is implied by EX_MemtoReg for a load; kept for interface completeness
  logic unused_ex_rw;
  assign unused_ex_rw = EX_RegWrite;
  // outputs are forced to their reset values while RST_N is low, independent of state
  always_comb begin
    run = RST_N && state == RUN;
    busy = RST_N && state == MDBUSY;
    lu = EX_MemtoReg && EX_Rdst != REG_ZERO &&
         ((ID_UsesRs && EX_Rdst == ID_Rs) || (ID_UsesRt && EX_Rdst == ID_Rt));
    StallF = busy || (run && !EX_BranchTaken && lu);
    StallD = StallF;
    FlushD = !RST_N || (run && EX_BranchTaken);
    FlushE = !RST_N || busy || (run && (EX_BranchTaken || lu));
    MD_Start = run && !EX_BranchTaken && !lu && ID_IsMulDiv;
    MD_Busy = busy;
    MD_Done = busy && cnt == CNT_W'(1);
    state_n = MD_Start ? MDBUSY : MD_Done ? RUN : state;
    cnt_n = MD_Start ? CNT_W'(MULDIV_CYCLES - 1) : busy ? cnt - CNT_W'(1) : cnt;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= RUN;
      cnt <= '0;
      e_rs <= REG_ZERO;
      e_rt <= REG_ZERO;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      e_rs <= FlushE ? REG_ZERO : ID_Rs & {5{ID_UsesRs}};
      e_rt <= FlushE ? REG_ZERO : ID_Rt & {5{ID_UsesRt}};
    end
  forward_unit u_fwd_a (
    .E_R(e_rs), .MEM_Rdst(MEM_Rdst), .MEM_RegWrite(MEM_RegWrite),
    .WB_Rdst(WB_Rdst), .WB_RegWrite(WB_RegWrite), .Fwd(ForwardAE)
  );
  forward_unit u_fwd_b (
    .E_R(e_rt), .MEM_Rdst(MEM_Rdst), .MEM_RegWrite(MEM_RegWrite),
    .WB_Rdst(WB_Rdst), .WB_RegWrite(WB_RegWrite), .Fwd(ForwardBE)
  );
`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      PerfStall <= '0;
      PerfFlush <= '0;
    end else begin
      PerfStall <= PerfStall + 32'(StallD);
      PerfFlush <= PerfFlush + 32'(FlushD);
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int MDC = 4;
  logic CLK = 0, RST_N = 0;
  logic [4:0] ID_Rs, ID_Rt, EX_Rdst, MEM_Rdst, WB_Rdst;
  logic ID_UsesRs, ID_UsesRt, ID_IsMulDiv, EX_RegWrite, EX_MemtoReg, EX_BranchTaken;
  logic MEM_RegWrite, WB_RegWrite;
  logic StallF, StallD, FlushD, FlushE, MD_Start, MD_Busy, MD_Done;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfStall, PerfFlush;
`endif
  int checks = 0, errors = 0;
  int busy_left = 0, ers = 0, ert = 0, perf_stall = 0, perf_flush = 0;
  always #5 CLK = ~CLK;
  hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs),
    .ID_UsesRt(ID_UsesRt), .ID_IsMulDiv(ID_IsMulDiv), .EX_Rdst(EX_Rdst),
    .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_BranchTaken(EX_BranchTaken),
    .MEM_Rdst(MEM_Rdst), .MEM_RegWrite(MEM_RegWrite), .WB_Rdst(WB_Rdst),
    .WB_RegWrite(WB_RegWrite), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MD_Start(MD_Start),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done)
`ifdef HAZARD_PERF_EN
    , .PerfStall(PerfStall), .PerfFlush(PerfFlush)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [1:0] fwd(input int e);
    if (e != 0 && MEM_RegWrite && int'(MEM_Rdst) == e) return 2'b10;
    if (e != 0 && WB_RegWrite && int'(WB_Rdst) == e) return 2'b01;
    return 2'b00;
  endfunction
  task automatic clr();
    {ID_Rs, ID_Rt, EX_Rdst, MEM_Rdst, WB_Rdst} = '0;
    {ID_UsesRs, ID_UsesRt, ID_IsMulDiv, EX_RegWrite, EX_MemtoReg, EX_BranchTaken} = '0;
    {MEM_RegWrite, WB_RegWrite} = '0;
  endtask
  task automatic rnd();
    ID_Rs = 5'($urandom_range(0, 3)); ID_Rt = 5'($urandom_range(0, 3));
    EX_Rdst = 5'($urandom_range(0, 3)); MEM_Rdst = 5'($urandom_range(0, 3));
    WB_Rdst = 5'($urandom_range(0, 3));
    ID_UsesRs = 1'($urandom); ID_UsesRt = 1'($urandom);
    ID_IsMulDiv = $urandom_range(0, 5) == 0; EX_RegWrite = 1'($urandom);
    EX_MemtoReg = 1'($urandom); EX_BranchTaken = $urandom_range(0, 6) == 0;
    MEM_RegWrite = 1'($urandom); WB_RegWrite = 1'($urandom);
  endtask
  // called at a negedge with inputs applied; checks, then advances the model over one posedge
  task automatic cycle();
    bit busy = 0, br = 0, lu = 0, ms = 0, st = 0, fe = 1, fd = 1;
    #1;
    if (!RST_N) begin
      busy_left = 0; ers = 0; ert = 0; perf_stall = 0; perf_flush = 0;
    end else begin
      busy = busy_left > 0;
      br = !busy && EX_BranchTaken;
      lu = !busy && !br && EX_MemtoReg && EX_Rdst != 0 &&
           ((ID_UsesRs && EX_Rdst == ID_Rs) || (ID_UsesRt && EX_Rdst == ID_Rt));
      ms = !busy && !br && !lu && ID_IsMulDiv;
      st = busy || lu;
      fe = busy || br || lu;
      fd = br;
    end
    chk("StallF", StallF, st);
    chk("StallD", StallD, st);
    chk("FlushD", FlushD, fd);
    chk("FlushE", FlushE, fe);
    chk("ForwardAE", ForwardAE, fwd(ers));
    chk("ForwardBE", ForwardBE, fwd(ert));
    chk("MD_Start", MD_Start, ms);
    chk("MD_Busy", MD_Busy, busy);
    chk("MD_Done", MD_Done, busy && busy_left == 1);
`ifdef HAZARD_PERF_EN
    chk("PerfStall", PerfStall, perf_stall);
    chk("PerfFlush", PerfFlush, perf_flush);
`endif
    @(posedge CLK);
    if (RST_N) begin
      busy_left = busy ? busy_left - 1 : ms ? MDC - 1 : 0;
      ers = fe ? 0 : (ID_UsesRs ? int'(ID_Rs) : 0);
      ert = fe ? 0 : (ID_UsesRt ? int'(ID_Rt) : 0);
      perf_stall += int'(st);
      perf_flush += int'(fd);
    end
    @(negedge CLK);
  endtask
  initial begin
    @(negedge CLK);
    repeat (3) begin rnd(); #1 chk("rst_flushd", FlushD, 1); cycle(); end
    clr(); RST_N = 1;
    EX_MemtoReg = 1; EX_RegWrite = 1; EX_Rdst = 8; ID_Rs = 8; ID_UsesRs = 1;
    #1 chk("lu_stall", StallF, 1);
    cycle();
    EX_MemtoReg = 0; EX_RegWrite = 0; EX_Rdst = 0; MEM_Rdst = 8; MEM_RegWrite = 1;
    #1 chk("lu_release", StallF, 0);
    cycle();
    clr(); WB_Rdst = 8; WB_RegWrite = 1;
    #1 chk("lu_fwd_wb", ForwardAE, 2'b01);
    cycle();
    clr(); ID_IsMulDiv = 1;
    #1 chk("md_start", MD_Start, 1);
    cycle();
    clr();
    for (int i = 0; i < MDC - 1; i++) begin
      #1 chk("md_busy", MD_Busy, 1);
      chk("md_done_seq", MD_Done, i == MDC - 2);
      cycle();
    end
    #1 chk("md_back_run", StallF, 0);
    EX_BranchTaken = 1; EX_MemtoReg = 1; EX_Rdst = 9; ID_Rs = 9; ID_UsesRs = 1;
    MEM_Rdst = 9; MEM_RegWrite = 1;
    #1 chk("br_stall", StallF, 0);
    chk("br_flushd", FlushD, 1);
    cycle();
    clr(); MEM_Rdst = 9; MEM_RegWrite = 1;
    #1 chk("br_shadow", ForwardAE, 2'b00);
`ifdef HAZARD_PERF_EN
    chk("perf_stall4", PerfStall, 4);
    chk("perf_flush1", PerfFlush, 1);
`endif
    cycle();
    clr(); ID_Rs = 5; ID_UsesRs = 1;
    cycle();
    clr(); MEM_Rdst = 5; MEM_RegWrite = 1; WB_Rdst = 5; WB_RegWrite = 1;
    #1 chk("fwd_mem_prio", ForwardAE, 2'b10);
    cycle();
    clr(); MEM_RegWrite = 1;
    #1 chk("fwd_zero", ForwardAE, 2'b00);
    cycle();
    clr(); ID_IsMulDiv = 1;
    cycle();
    clr();
    cycle();
    #1 chk("abort_busy", MD_Busy, 1);
    #2 RST_N = 0;
    #1 chk("abort_busy_clr", MD_Busy, 0);
    chk("abort_flushd", FlushD, 1);
    chk("abort_stall", StallF, 0);
    @(negedge CLK);
    busy_left = 0; ers = 0; ert = 0; perf_stall = 0; perf_flush = 0;
    RST_N = 1;
    repeat (4) cycle();
    for (int i = 0; i < 400; i++) begin
      rnd();
      RST_N = $urandom_range(0, 40) != 0;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU.
- Decides stall, flush and forwarding for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, taken-branch flushes and operand forwarding.
- Runs a multi-cycle mul/div busy sequence that freezes the front end and injects bubbles into ID/EX.

Parameters:
- MULDIV_CYCLES, 32: EX occupancy of a mul/div instruction in cycles; legal range 2..64.
- CNT_W, 6: width of the internal mul/div down-counter; must satisfy 2^CNT_W >= MULDIV_CYCLES.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- ID_IsMulDiv  in  1  ID instruction is mult/div.
- EX_Rdst  in  5  destination register of the EX instruction (after RegDst mux).
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_MemtoReg  in  1  EX instruction is a load.
- EX_BranchTaken  in  1  branch in EX resolved taken.
- MEM_Rdst  in  5  destination register of the MEM instruction.
- MEM_RegWrite  in  1  MEM instruction writes the register file.
- WB_Rdst  in  5  destination register of the WB instruction.
- WB_RegWrite  in  1  WB instruction writes the register file.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- FlushD  out  1  zero IF/ID on next edge.
- FlushE  out  1  load a bubble into ID/EX (all control fields 0) on next edge.
- ForwardAE  out  2  EX operand A select: 00 reg file, 01 WB, 10 MEM.
- ForwardBE  out  2  EX operand B select; same encoding as ForwardAE.
- MD_Start  out  1  one-cycle pulse: mul/div enters EX.
- MD_Busy  out  1  mul/div sequence in progress.
- MD_Done  out  1  one-cycle pulse on the final busy cycle.

Behaviour:
- States: RUN, MDBUSY.
  - Registered: state, CNT_W-bit counter, shadow E_Rs/E_Rt (rs/rt of the EX instruction).
  - All outputs are combinational from state, shadows and inputs.
- Reset (RST_N low, asynchronous):
  - state=RUN, counter=0, E_Rs=E_Rt=0.
  - Outputs while in reset: StallF=StallD=0, FlushD=FlushE=1, Forward*=00, MD_*=0.
  - Reset mid-sequence abandons the mul/div with no MD_Done.
- Load-use hazard (LU), RUN only: EX_MemtoReg && EX_Rdst!=0 && ((ID_UsesRs && EX_Rdst==ID_Rs) || (ID_UsesRt && EX_Rdst==ID_Rt)).
- Priority in RUN: EX_BranchTaken > LU > ID_IsMulDiv > normal.
  - Branch taken: FlushD=1, FlushE=1, no stall; LU and mul/div start are suppressed that cycle.
  - LU: StallF=StallD=1, FlushE=1 for exactly one cycle; the next cycle re-evaluates with the load in MEM.
  - ID_IsMulDiv with no branch/LU: MD_Start=1, instruction advances normally; next state MDBUSY, counter=MULDIV_CYCLES-1.
- MDBUSY:
  - StallF=StallD=1, FlushE=1, MD_Busy=1; EX_BranchTaken ignored.
  - Counter decrements each cycle.
  - When counter==1: MD_Done=1 and next state RUN.
  - Total busy cycles = MULDIV_CYCLES-1 after the start cycle.
  - A mul/div in ID immediately after MDBUSY starts a new sequence normally (back-to-back).
- Shadow update each edge:
  - If FlushE=1: E_Rs=E_Rt=0.
  - Else: E_Rs=ID_Rs & {5{ID_UsesRs}}, E_Rt=ID_Rt & {5{ID_UsesRt}}.
- Forwarding (X = Rs/A or Rt/B):
  - 10 if MEM_RegWrite && MEM_Rdst!=0 && MEM_Rdst==E_X.
  - Else 01 if WB_RegWrite && WB_Rdst!=0 && WB_Rdst==E_X.
  - Else 00.
  - MEM wins when both stages match. Register $0 is never forwarded.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs PerfStall[31:0] and PerfFlush[31:0].
  - PerfStall increments on every cycle with StallD=1.
  - PerfFlush increments on every cycle with FlushD=1.
  - Both wrap at 2^32, reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - state enum {RUN, MDBUSY}.
  - REG_ZERO=5'd0.
- Sub-module forward_unit: pure combinational MEM/WB priority compare; instantiated twice, for A and B.

Test Plan:
- Reset: hold RST_N=0 with random inputs -> FlushD=FlushE=1, StallF=0, Forward=00; release -> state RUN, E_Rs=0.
- Load-use: EX lw $8 (EX_MemtoReg=1, EX_Rdst=8), ID add reads rs=8 -> one cycle StallF=StallD=FlushE=1; next cycle ForwardAE=01 once the load reaches WB.
- Forward priority: E_Rs=5, MEM_Rdst=5 and WB_Rdst=5 both writing -> ForwardAE=10; MEM_Rdst=0 with E_Rs=0 -> 00.
- Branch over hazard: EX_BranchTaken=1 coinciding with LU condition -> FlushD=FlushE=1, StallF=0; shadows cleared next cycle.
- Mul/div with MULDIV_CYCLES=4: ID_IsMulDiv=1 -> MD_Start pulse, then 3 cycles MD_Busy/Stall/FlushE with MD_Done on the 3rd, then RUN; assert RST_N low in cycle 2 -> immediate RUN, no MD_Done.
- HAZARD_PERF_EN: 1 LU plus 4-cycle mul/div plus 1 taken branch -> PerfStall=4, PerfFlush=1.
